sdes_stream_ctrl: RTL and testbench
===================================

# sdes_stream_ctrl

Clocked sequencer that feeds a byte stream through the existing combinational S-DES `key_gen`, `Encrypt` and `Decrypt` cores in ECB or CBC mode. Upstream and downstream connect through valid/ready handshakes. The block owns the key register, the registered subkeys, the chaining (IV) register and a byte counter. It sits between a byte source (switch loader, UART or test driver) and a byte sink (display registers or UART TX).

## Interface
Parameters:
- none; widths are fixed by S-DES (10-bit key, 8-bit block).

Ports:
- `CLOCK_50` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `key10_in` in 10: raw key.
- `key_load` in 1: one-cycle pulse that captures `key10_in`.
- `iv_in` in 8: initialisation vector.
- `iv_load` in 1: one-cycle pulse that captures `iv_in` into the chain register and clears `byte_count`.
- `mode` in 1: 0 = ECB, 1 = CBC; sampled when a byte is accepted.
- `dir` in 1: 1 = encrypt, 0 = decrypt; sampled when a byte is accepted.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 8: input byte handshake.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 8: result byte handshake.
- `busy` out 1: high in LOAD_KEY, CIPHER and OUTPUT.
- `byte_count` out 8: number of completed output handshakes since the last `iv_load` or reset.

## Operation
- States: IDLE, LOAD_KEY, READY, CIPHER, OUTPUT.
- IDLE: `in_ready` = 0. On `key_load`, latch the key and go to LOAD_KEY.
- LOAD_KEY (1 cycle):
  - `key_gen` is driven with the key in reversed bit order: {k[0], k[1], …, k[9]}.
  - Register `subkey1` and `subkey2`, then go to READY.
- READY:
  - `in_ready` = !`key_load` && !`iv_load`.
  - On `key_load`, go to LOAD_KEY. `iv_load` in the same cycle also takes effect.
  - `iv_load` alone: chain ← `iv_in`, `byte_count` ← 0, stay in READY.
  - On `in_valid` && `in_ready`: capture `in_data`, `mode` and `dir`, then go to CIPHER.
- CIPHER (1 cycle): compute the result with the registered subkeys and load it into `out_data`.
  - CBC encrypt: out = E(P ⊕ chain); chain ← out.
  - CBC decrypt: out = D(C) ⊕ chain; chain ← C (the captured input byte).
  - ECB: out = E(P) or D(C); chain unchanged.
  - Go to OUTPUT.
- OUTPUT:
  - `out_valid` = 1; `out_data` is held stable.
  - On `out_ready`: `byte_count` increments, then go to READY.
- `key_load` and `iv_load` are ignored in CIPHER and OUTPUT; they are not queued.
- `byte_count` wraps from 255 to 0 with no flag.
- `mode` and `dir` may change between bytes. An ECB byte never touches the chain, so a following CBC byte continues from the last CBC state.

## Timing
- Reset (asynchronous, any state): all of the following are cleared and the FSM returns to IDLE.
  - state = IDLE.
  - key, subkeys, chain, `out_data`, `byte_count` = 0.
  - `in_ready`, `out_valid`, `busy` = 0.
- Reset mid-operation discards any in-flight byte; no partial output is produced.
- Latency:
  - `key_load` edge to `in_ready` high: 2 cycles (LOAD_KEY, then READY).
  - Input accept at cycle N: CIPHER at N+1, `out_valid` high at N+2.
- Throughput: at most one byte per 3 cycles (READY → CIPHER → OUTPUT).
- `out_ready` high at N+2 completes the handshake at N+2; READY follows at N+3.
- `out_valid` stays high with `out_data` stable until `out_ready`; back-pressure can hold it indefinitely.
- `in_ready` is combinational from state, `key_load` and `iv_load`. `out_valid` and `busy` are decoded from state only, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `sdes_pkg`:
  - state enum;
  - `SDES_KEY_W` = 10, `SDES_BLK_W` = 8;
  - `MODE_ECB` / `MODE_CBC`, `DIR_DEC` / `DIR_ENC` constants.
- Instantiate the existing `key_gen`, `Encrypt` and `Decrypt` as-is.
- Sub-module `sdes_chain_unit`: pre-XOR, post-XOR and chain-register update, selected by `mode` and `dir`.
- All remaining logic (FSM, counter, handshake) lives in the top-level block.

## Test plan
- Reset, then `key_load` with `key10_in` = 10'b0100000101 → `in_ready` high 2 cycles later; registered subkeys = 8'hA4, 8'h43.
- ECB encrypt 8'h72 with that key → `out_valid` 2 cycles after accept, `out_data` = 8'h77. Decrypting 8'h77 → 8'h72.
- CBC with IV = 8'h5A, encrypt 8'h72 then 8'h72 → the two ciphertexts differ. CBC-decrypting them with the same IV returns 8'h72, 8'h72; `byte_count` = 2.
- Hold `out_ready` low for 10 cycles → `out_valid` and `out_data` stable, `in_ready` low throughout. Assert `iv_load` during OUTPUT → chain unchanged.
- Run 256 ECB bytes → `byte_count` wraps to 0.
- Assert `reset_n` low in CIPHER → all outputs 0 immediately, FSM in IDLE. After a fresh `key_load`, the output matches the golden model.

Source files
------------

// File: rtl/sdes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sdes_pkg
//  Description : Shared S-DES widths, mode/direction codes, sequencer state
//                encoding and the bit-level S-DES primitives (IP, IP^-1, fK,
//                P8, S-boxes) used by the cipher cores.
//  Revision    : 1.0  initial release
// ============================================================================
package sdes_pkg;

  localparam int SDES_KEY_W = 10;
  localparam int SDES_BLK_W = 8;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;
  localparam logic DIR_DEC  = 1'b0;
  localparam logic DIR_ENC  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_READY    = 3'd2,
    ST_CIPHER   = 3'd3,
    ST_OUTPUT   = 3'd4
  } state_e;

  // Bit positions below are the textbook 1-based, MSB-first positions,
  // so position n of an 8-bit block is bit [8-n].

  // Initial permutation 2 6 3 1 4 8 5 7
  function automatic logic [7:0] sdes_ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  // Inverse initial permutation 4 1 3 5 7 2 8 6
  function automatic logic [7:0] sdes_ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction

  // P8 subkey compression 6 3 7 4 8 5 10 9 over the 10-bit shifted key
  function automatic logic [7:0] sdes_p8(input logic [9:0] x);
    return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
  endfunction

  // S-box row is outer bits (1,4), column is inner bits (2,3)
  function automatic logic [1:0] sdes_s0(input logic [3:0] x);
    logic [1:0] r;
    r = 2'd0;
    case ({x[3], x[0], x[2], x[1]})
      4'd0:  r = 2'd1;
      4'd1:  r = 2'd0;
      4'd2:  r = 2'd3;
      4'd3:  r = 2'd2;
      4'd4:  r = 2'd3;
      4'd5:  r = 2'd2;
      4'd6:  r = 2'd1;
      4'd7:  r = 2'd0;
      4'd8:  r = 2'd0;
      4'd9:  r = 2'd2;
      4'd10: r = 2'd1;
      4'd11: r = 2'd3;
      4'd12: r = 2'd3;
      4'd13: r = 2'd1;
      4'd14: r = 2'd3;
      default: r = 2'd2;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sdes_s1(input logic [3:0] x);
    logic [1:0] r;
    r = 2'd0;
    case ({x[3], x[0], x[2], x[1]})
      4'd0:  r = 2'd0;
      4'd1:  r = 2'd1;
      4'd2:  r = 2'd2;
      4'd3:  r = 2'd3;
      4'd4:  r = 2'd2;
      4'd5:  r = 2'd0;
      4'd6:  r = 2'd1;
      4'd7:  r = 2'd3;
      4'd8:  r = 2'd3;
      4'd9:  r = 2'd0;
      4'd10: r = 2'd1;
      4'd11: r = 2'd0;
      4'd12: r = 2'd2;
      4'd13: r = 2'd1;
      4'd14: r = 2'd0;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Round function: E/P 4 1 2 3 2 3 4 1, key mix, S-boxes, P4 2 4 3 1
  function automatic logic [3:0] sdes_f(input logic [3:0] r, input logic [7:0] sk);
    logic [7:0] x;
    logic [3:0] s;
    x = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ sk;
    s = {sdes_s0(x[7:4]), sdes_s1(x[3:0])};
    return {s[2], s[0], s[1], s[3]};
  endfunction

  // fK mixes the left nibble with F(right nibble); right nibble passes through
  function automatic logic [7:0] sdes_fk(input logic [7:0] d, input logic [7:0] sk);
    return {d[7:4] ^ sdes_f(d[3:0], sk), d[3:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdes_stream_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sdes_stream_ctrl_if
//  Description : Byte-stream handshakes of the S-DES sequencer: input
//                valid/ready/data and result valid/ready/data.
//                master = byte source/sink side, slave = sequencer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface sdes_stream_ctrl_if;
  import sdes_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [SDES_BLK_W-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SDES_BLK_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface
`default_nettype wire

// File: rtl/Decrypt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : Decrypt
//  Description : Combinational S-DES block decrypt: the encrypt structure with
//                the subkeys applied in reverse order.
//  Revision    : 1.0  initial release
// ============================================================================
module Decrypt
  import sdes_pkg::*;
(
  input  logic [SDES_BLK_W-1:0] ciphertext,
  input  logic [SDES_BLK_W-1:0] k1,
  input  logic [SDES_BLK_W-1:0] k2,
  output logic [SDES_BLK_W-1:0] plaintext
);

  logic [7:0] r1;
  logic [7:0] r2;

  assign r1        = sdes_fk(sdes_ip(ciphertext), k2);
  assign r2        = sdes_fk({r1[3:0], r1[7:4]}, k1);
  assign plaintext = sdes_ip_inv(r2);

endmodule
`default_nettype wire

// File: rtl/Encrypt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : Encrypt
//  Description : Combinational S-DES block encrypt: IP, fK(k1), SW, fK(k2),
//                IP^-1.
//  Revision    : 1.0  initial release
// ============================================================================
module Encrypt
  import sdes_pkg::*;
(
  input  logic [SDES_BLK_W-1:0] plaintext,
  input  logic [SDES_BLK_W-1:0] k1,
  input  logic [SDES_BLK_W-1:0] k2,
  output logic [SDES_BLK_W-1:0] ciphertext
);

  logic [7:0] r1;
  logic [7:0] r2;

  assign r1         = sdes_fk(sdes_ip(plaintext), k1);
  assign r2         = sdes_fk({r1[3:0], r1[7:4]}, k2);
  assign ciphertext = sdes_ip_inv(r2);

endmodule
`default_nettype wire

// File: rtl/key_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : key_gen
//  Description : Combinational S-DES subkey generator (P10, LS-1, P8, LS-2,
//                P8).
//  Revision    : 1.0  initial release
// ============================================================================
module key_gen
  import sdes_pkg::*;
(
  input  logic [SDES_KEY_W-1:0] key,
  output logic [SDES_BLK_W-1:0] k1,
  output logic [SDES_BLK_W-1:0] k2
);

  logic [9:0] p10;
  logic [9:0] ls1;
  logic [9:0] ls2;

  // P10 3 5 2 7 4 10 1 9 8 6
  assign p10 = {key[7], key[5], key[8], key[3], key[6],
                key[0], key[9], key[1], key[2], key[4]};
  // Each 5-bit half rotates left by one, then by two more
  assign ls1 = {p10[8:5], p10[9], p10[3:0], p10[4]};
  assign ls2 = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};

  assign k1 = sdes_p8(ls1);
  assign k2 = sdes_p8(ls2);

endmodule
`default_nettype wire

// File: rtl/sdes_chain_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sdes_chain_unit
//  Description : CBC chaining around the cipher cores: pre-XOR of the
//                plaintext, post-XOR of the decrypted block and the chain
//                (IV) register. ECB bytes bypass the XORs and leave the chain
//                untouched.
//  Revision    : 1.0  initial release
// ============================================================================
module sdes_chain_unit
  import sdes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iv_load,
  input  logic [SDES_BLK_W-1:0] iv_in,
  input  logic                  update,
  input  logic                  mode,
  input  logic                  dir,
  input  logic [SDES_BLK_W-1:0] data_in,
  input  logic [SDES_BLK_W-1:0] enc_out,
  input  logic [SDES_BLK_W-1:0] dec_out,
  output logic [SDES_BLK_W-1:0] enc_in,
  output logic [SDES_BLK_W-1:0] result
);

  logic [SDES_BLK_W-1:0] chain_q;
  logic [SDES_BLK_W-1:0] chain_d;

  // Pre-XOR into the encrypt core, post-XOR out of the decrypt core, and the
  // next chain value (ciphertext of this byte in either direction)
  always_comb begin
    enc_in  = data_in;
    result  = enc_out;
    chain_d = chain_q;

    case (mode)
      MODE_CBC: enc_in = data_in ^ chain_q;
      default:  enc_in = data_in;
    endcase

    case (dir)
      DIR_ENC: result = enc_out;
      default: result = (mode == MODE_CBC) ? (dec_out ^ chain_q) : dec_out;
    endcase

    if (iv_load) begin
      chain_d = iv_in;
    end else if (update && (mode != MODE_ECB)) begin
      chain_d = (dir == DIR_ENC) ? result : data_in;
    end
  end

  // Chain register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdes_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sdes_stream_ctrl
//  Description : Byte-stream S-DES sequencer (ECB/CBC, encrypt/decrypt) with
//                valid/ready handshakes, key and subkey registers, chaining
//                and an output byte counter.
//  Revision    : 1.0  initial release
// ============================================================================
module sdes_stream_ctrl
  import sdes_pkg::*;
(
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic [SDES_KEY_W-1:0] key10_in,
  input  logic                  key_load,
  input  logic [SDES_BLK_W-1:0] iv_in,
  input  logic                  iv_load,
  input  logic                  mode,
  input  logic                  dir,
  sdes_stream_ctrl_if.slave     s_if,
  output logic                  busy,
  output logic [7:0]            byte_count
);

  state_e                state_q,      state_d;
  logic [SDES_KEY_W-1:0] key_q,        key_d;
  logic [SDES_BLK_W-1:0] subkey1_q,    subkey1_d;
  logic [SDES_BLK_W-1:0] subkey2_q,    subkey2_d;
  logic [SDES_BLK_W-1:0] din_q,        din_d;
  logic                  mode_q,       mode_d;
  logic                  dir_q,        dir_d;
  logic [SDES_BLK_W-1:0] out_data_q,   out_data_d;
  logic [7:0]            byte_count_q, byte_count_d;

  logic                  in_ready;
  logic                  iv_take;
  logic                  chain_update;
  logic [SDES_KEY_W-1:0] key_rev;
  logic [SDES_BLK_W-1:0] kg_k1;
  logic [SDES_BLK_W-1:0] kg_k2;
  logic [SDES_BLK_W-1:0] enc_in;
  logic [SDES_BLK_W-1:0] enc_out;
  logic [SDES_BLK_W-1:0] dec_out;
  logic [SDES_BLK_W-1:0] result;

  // The board loader presents the key LSB-first relative to key_gen
  for (genvar i = 0; i < SDES_KEY_W; i++) begin : g_key_rev
    assign key_rev[i] = key_q[SDES_KEY_W-1-i];
  end

  key_gen u_key_gen (
    .key (key_rev),
    .k1  (kg_k1),
    .k2  (kg_k2)
  );

  Encrypt u_enc (
    .plaintext  (enc_in),
    .k1         (subkey1_q),
    .k2         (subkey2_q),
    .ciphertext (enc_out)
  );

  Decrypt u_dec (
    .ciphertext (din_q),
    .k1         (subkey1_q),
    .k2         (subkey2_q),
    .plaintext  (dec_out)
  );

  sdes_chain_unit u_chain (
    .clk     (CLOCK_50),
    .rst_n   (reset_n),
    .iv_load (iv_take),
    .iv_in   (iv_in),
    .update  (chain_update),
    .mode    (mode_q),
    .dir     (dir_q),
    .data_in (din_q),
    .enc_out (enc_out),
    .dec_out (dec_out),
    .enc_in  (enc_in),
    .result  (result)
  );

  // Next-state, handshake and datapath-load decode
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    subkey1_d    = subkey1_q;
    subkey2_d    = subkey2_q;
    din_d        = din_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    out_data_d   = out_data_q;
    byte_count_d = byte_count_q;
    in_ready     = 1'b0;
    iv_take      = 1'b0;
    chain_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        iv_take = iv_load;
        if (key_load) begin
          key_d   = key10_in;
          state_d = ST_LOAD_KEY;
        end
      end

      ST_LOAD_KEY: begin
        iv_take   = iv_load;
        subkey1_d = kg_k1;
        subkey2_d = kg_k2;
        state_d   = ST_READY;
        // A back-to-back key_load restarts expansion on the newer key
        if (key_load) begin
          key_d   = key10_in;
          state_d = ST_LOAD_KEY;
        end
      end

      ST_READY: begin
        iv_take  = iv_load;
        in_ready = !key_load && !iv_load;
        if (key_load) begin
          key_d   = key10_in;
          state_d = ST_LOAD_KEY;
        end else if (s_if.in_valid && in_ready) begin
          din_d   = s_if.in_data;
          mode_d  = mode;
          dir_d   = dir;
          state_d = ST_CIPHER;
        end
      end

      ST_CIPHER: begin
        out_data_d   = result;
        chain_update = 1'b1;
        state_d      = ST_OUTPUT;
      end

      ST_OUTPUT: begin
        if (s_if.out_ready) begin
          byte_count_d = byte_count_q + 8'd1;
          state_d      = ST_READY;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // iv_take is never set in OUTPUT, so this cannot collide with the increment
    if (iv_take) begin
      byte_count_d = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      subkey1_q    <= '0;
      subkey2_q    <= '0;
      din_q        <= '0;
      mode_q       <= 1'b0;
      dir_q        <= 1'b0;
      out_data_q   <= '0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      subkey1_q    <= subkey1_d;
      subkey2_q    <= subkey2_d;
      din_q        <= din_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      out_data_q   <= out_data_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign s_if.in_ready  = in_ready;
  assign s_if.out_valid = (state_q == ST_OUTPUT);
  assign s_if.out_data  = out_data_q;
  assign busy           = (state_q == ST_LOAD_KEY) || (state_q == ST_CIPHER) ||
                          (state_q == ST_OUTPUT);
  assign byte_count     = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sdes_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sdes_stream_ctrl
//  Description : Scoreboard bench for sdes_stream_ctrl with a table-driven
//                S-DES reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdes_stream_ctrl;
  import sdes_pkg::*;

  // Permutation tables, one hex nibble per 1-based source position, left-first
  localparam logic [39:0] T_P10 = 40'h35274A1986;
  localparam logic [39:0] T_P8  = 40'h637485A900;
  localparam logic [39:0] T_IP  = 40'h2631485700;
  localparam logic [39:0] T_IPI = 40'h4135728600;
  localparam logic [39:0] T_EP  = 40'h4123234100;
  localparam logic [39:0] T_P4  = 40'h2431000000;
  // S-boxes, row-major, 2 bits per entry
  localparam logic [31:0] T_S0  = 32'h4EE427DE;
  localparam logic [31:0] T_S1  = 32'h1B87C493;

  logic       clk;
  logic       reset_n;
  logic [9:0] key10_in;
  logic       key_load;
  logic [7:0] iv_in;
  logic       iv_load;
  logic       mode;
  logic       dir;
  logic       busy;
  logic [7:0] byte_count;

  sdes_stream_ctrl_if sif ();

  sdes_stream_ctrl dut (
    .CLOCK_50   (clk),
    .reset_n    (reset_n),
    .key10_in   (key10_in),
    .key_load   (key_load),
    .iv_in      (iv_in),
    .iv_load    (iv_load),
    .mode       (mode),
    .dir        (dir),
    .s_if       (sif.slave),
    .busy       (busy),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         n_vec;
  int         n_err;
  logic [7:0] sb[$];
  logic [7:0] m_k1;
  logic [7:0] m_k2;
  logic [7:0] m_chain;
  logic [7:0] m_count;

  // ---------------- reference model ----------------
  function automatic logic [9:0] m_perm(input logic [9:0] src, input int in_w,
                                        input int out_w, input logic [39:0] tbl);
    logic [9:0] r;
    int pos;
    r = '0;
    for (int j = 0; j < out_w; j++) begin
      pos = int'(tbl[4*(9-j) +: 4]);
      r[out_w-1-j] = src[in_w-pos];
    end
    return r;
  endfunction

  function automatic logic [1:0] m_sbox(input logic [31:0] tbl, input logic [3:0] x);
    int idx;
    idx = int'({x[3], x[0], x[2], x[1]});
    return tbl[2*(15-idx) +: 2];
  endfunction

  function automatic logic [7:0] m_round(input logic [7:0] d, input logic [7:0] sk);
    logic [9:0] ep;
    logic [9:0] p4;
    logic [7:0] x;
    logic [3:0] s;
    ep = m_perm({6'd0, d[3:0]}, 4, 8, T_EP);
    x  = ep[7:0] ^ sk;
    s  = {m_sbox(T_S0, x[7:4]), m_sbox(T_S1, x[3:0])};
    p4 = m_perm({6'd0, s}, 4, 4, T_P4);
    return {d[7:4] ^ p4[3:0], d[3:0]};
  endfunction

  function automatic logic [7:0] m_crypt(input logic [7:0] b, input logic [7:0] ka,
                                         input logic [7:0] kb);
    logic [9:0] t;
    logic [7:0] u;
    t = m_perm({2'd0, b}, 8, 8, T_IP);
    u = m_round(t[7:0], ka);
    u = m_round({u[3:0], u[7:4]}, kb);
    t = m_perm({2'd0, u}, 8, 8, T_IPI);
    return t[7:0];
  endfunction

  function automatic logic [15:0] m_keygen(input logic [9:0] key);
    logic [9:0] rev;
    logic [9:0] p;
    logic [4:0] l;
    logic [4:0] r;
    logic [9:0] a;
    logic [9:0] b;
    for (int i = 0; i < 10; i++) rev[i] = key[9-i];
    p = m_perm(rev, 10, 10, T_P10);
    l = {p[8:5], p[9]};
    r = {p[3:0], p[4]};
    a = m_perm({l, r}, 10, 8, T_P8);
    l = {l[2:0], l[4:3]};
    r = {r[2:0], r[4:3]};
    b = m_perm({l, r}, 10, 8, T_P8);
    return {a[7:0], b[7:0]};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic iv_pulse(input logic [7:0] v);
    iv_in   = v;
    iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    m_chain = v;
    m_count = 8'd0;
    #1;
    n_vec++;
    if (byte_count !== 8'd0) begin
      n_err++;
      $display("FAIL iv_clear: byte_count=%0d required 0", byte_count);
    end
  endtask

  // One byte through the block; hold = cycles of out_ready low once out_valid
  // is up; poke pulses key_load/iv_load during that hold.
  task automatic do_xfer(input logic [7:0] p, input logic m, input logic d,
                         input int hold, input bit poke, output logic [7:0] got);
    logic [7:0] exp;
    logic [7:0] held;
    int t;
    if (m == MODE_CBC && d == DIR_ENC) begin
      exp = m_crypt(p ^ m_chain, m_k1, m_k2);
      m_chain = exp;
    end else if (m == MODE_CBC) begin
      exp = m_crypt(p, m_k2, m_k1) ^ m_chain;
      m_chain = p;
    end else if (d == DIR_ENC) begin
      exp = m_crypt(p, m_k1, m_k2);
    end else begin
      exp = m_crypt(p, m_k2, m_k1);
    end
    sb.push_back(exp);

    sif.in_data  = p;
    mode         = m;
    dir          = d;
    sif.in_valid = 1'b1;
    #1;
    t = 0;
    while (sif.in_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (sif.in_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", sif.in_ready);
    end
    tick();
    // Scramble the inputs: the captured copies must be used from here on
    sif.in_valid = 1'b0;
    sif.in_data  = ~p;
    mode         = ~m;
    dir          = ~d;
    #1;
    n_vec++;
    if ({sif.out_valid, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL cipher_phase: out_valid,busy=%b required 01", {sif.out_valid, busy});
    end
    tick();
    n_vec++;
    if (sif.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL out_latency: out_valid=%b required 1", sif.out_valid);
    end
    held = sif.out_data;
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 3) begin
        iv_in    = 8'hC3;
        iv_load  = 1'b1;
        key10_in = 10'($urandom);
        key_load = 1'b1;
      end
      #1;
      n_vec++;
      if (sif.out_valid !== 1'b1 || sif.out_data !== held || sif.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold: valid=%b data=%h ready=%b required 1 %h 0",
                 sif.out_valid, sif.out_data, sif.in_ready, held);
      end
      tick();
      iv_load  = 1'b0;
      key_load = 1'b0;
    end
    got = sif.out_data;
    exp = sb.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL out_data: got %h required %h (in %h mode %b dir %b)", got, exp, p, m, d);
    end
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    m_count = m_count + 8'd1;
    #1;
    n_vec++;
    if (byte_count !== m_count || sif.in_ready !== 1'b1 || sif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL after_handshake: count=%0d ready=%b valid=%b required %0d 1 0",
               byte_count, sif.in_ready, sif.out_valid, m_count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({sif.in_ready, sif.out_valid, busy} !== 3'b000 || sif.out_data !== 8'd0 ||
        byte_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy/vld/busy=%b data=%h count=%0d required 000 00 0",
               {sif.in_ready, sif.out_valid, busy}, sif.out_data, byte_count);
    end
    n_vec++;
    if (dut.state_q !== ST_IDLE || dut.subkey1_q !== 8'd0 || dut.u_chain.chain_q !== 8'd0) begin
      n_err++;
      $display("FAIL reset_state: state=%0d sk1=%h chain=%h required 0 00 00",
               dut.state_q, dut.subkey1_q, dut.u_chain.chain_q);
    end
    reset_n = 1'b1;
    tick();
    n_vec++;
    if (sif.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_not_ready: in_ready=%b required 0", sif.in_ready);
    end
    m_chain = 8'd0;
    m_count = 8'd0;
  endtask

  task automatic test_key_load(input logic [9:0] k, input bit known);
    logic [15:0] ks;
    ks       = m_keygen(k);
    m_k1     = ks[15:8];
    m_k2     = ks[7:0];
    key10_in = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    key10_in = 10'($urandom);
    #1;
    n_vec++;
    if ({sif.in_ready, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL load_key_phase: in_ready,busy=%b required 01", {sif.in_ready, busy});
    end
    tick();
    #1;
    n_vec++;
    if ({sif.in_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL key_to_ready: in_ready,busy=%b required 10", {sif.in_ready, busy});
    end
    n_vec++;
    if (dut.subkey1_q !== m_k1 || dut.subkey2_q !== m_k2) begin
      n_err++;
      $display("FAIL subkeys: got %h %h required %h %h", dut.subkey1_q, dut.subkey2_q, m_k1, m_k2);
    end
    if (known) begin
      n_vec++;
      if (dut.subkey1_q !== 8'hA4 || dut.subkey2_q !== 8'h43) begin
        n_err++;
        $display("FAIL subkeys_known: got %h %h required a4 43", dut.subkey1_q, dut.subkey2_q);
      end
    end
  endtask

  task automatic test_ecb();
    logic [7:0] got;
    do_xfer(8'h72, MODE_ECB, DIR_ENC, 0, 1'b0, got);
    n_vec++;
    if (got !== 8'h77) begin
      n_err++;
      $display("FAIL ecb_known_enc: got %h required 77", got);
    end
    do_xfer(8'h77, MODE_ECB, DIR_DEC, 0, 1'b0, got);
    n_vec++;
    if (got !== 8'h72) begin
      n_err++;
      $display("FAIL ecb_known_dec: got %h required 72", got);
    end
    for (int i = 0; i < 4; i++) do_xfer(8'($urandom), MODE_ECB, 1'($urandom), 0, 1'b0, got);
  endtask

  task automatic test_cbc();
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] got;
    iv_pulse(8'h5A);
    do_xfer(8'h72, MODE_CBC, DIR_ENC, 0, 1'b0, c1);
    do_xfer(8'h72, MODE_CBC, DIR_ENC, 0, 1'b0, c2);
    n_vec++;
    if (c1 === c2) begin
      n_err++;
      $display("FAIL cbc_chaining: second block %h required to differ from first %h", c2, c1);
    end
    iv_pulse(8'h5A);
    do_xfer(c1, MODE_CBC, DIR_DEC, 0, 1'b0, got);
    n_vec++;
    if (got !== 8'h72) begin
      n_err++;
      $display("FAIL cbc_dec1: got %h required 72", got);
    end
    do_xfer(c2, MODE_CBC, DIR_DEC, 0, 1'b0, got);
    n_vec++;
    if (got !== 8'h72 || byte_count !== 8'd2) begin
      n_err++;
      $display("FAIL cbc_dec2: got %h count %0d required 72 2", got, byte_count);
    end
    // ECB in between must leave the chain where CBC left it
    do_xfer(8'h3C, MODE_CBC, DIR_ENC, 0, 1'b0, got);
    do_xfer(8'hA5, MODE_ECB, DIR_ENC, 0, 1'b0, got);
    do_xfer(8'h3C, MODE_CBC, DIR_ENC, 0, 1'b0, got);
    do_xfer(8'h81, MODE_CBC, DIR_DEC, 0, 1'b0, got);
  endtask

  task automatic test_backpressure();
    logic [7:0] got;
    do_xfer(8'($urandom), MODE_CBC, DIR_ENC, 10, 1'b1, got);
    n_vec++;
    if (dut.u_chain.chain_q !== m_chain) begin
      n_err++;
      $display("FAIL iv_ignored_in_output: chain=%h required %h", dut.u_chain.chain_q, m_chain);
    end
    // Ignored key_load means the old subkeys still apply
    do_xfer(8'($urandom), MODE_CBC, DIR_ENC, 0, 1'b0, got);
  endtask

  task automatic test_wrap();
    logic [7:0] got;
    iv_pulse(8'h00);
    for (int i = 0; i < 256; i++) begin
      do_xfer(8'($urandom), MODE_ECB, 1'($urandom), 0, 1'b0, got);
      if (i == 254) begin
        n_vec++;
        if (byte_count !== 8'd255) begin
          n_err++;
          $display("FAIL count_255: byte_count=%0d required 255", byte_count);
        end
      end
    end
    n_vec++;
    if (byte_count !== 8'd0) begin
      n_err++;
      $display("FAIL count_wrap: byte_count=%0d required 0", byte_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    sif.in_data  = 8'h5E;
    mode         = MODE_ECB;
    dir          = DIR_ENC;
    sif.in_valid = 1'b1;
    tick();
    sif.in_valid = 1'b0;
    #1;
    n_vec++;
    if (dut.state_q !== ST_CIPHER) begin
      n_err++;
      $display("FAIL reach_cipher: state=%0d required %0d", dut.state_q, ST_CIPHER);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({sif.in_ready, sif.out_valid, busy} !== 3'b000 || sif.out_data !== 8'd0 ||
        byte_count !== 8'd0 || dut.state_q !== ST_IDLE) begin
      n_err++;
      $display("FAIL async_reset: rdy/vld/busy=%b data=%h count=%0d state=%0d required 000 00 0 0",
               {sif.in_ready, sif.out_valid, busy}, sif.out_data, byte_count, dut.state_q);
    end
    tick();
    tick();
    n_vec++;
    if (sif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL no_partial_output: out_valid=%b required 0", sif.out_valid);
    end
    reset_n = 1'b1;
    sb.delete();
    m_chain = 8'd0;
    m_count = 8'd0;
    tick();
    test_key_load(10'($urandom), 1'b0);
    do_xfer(8'($urandom), MODE_ECB, DIR_ENC, 0, 1'b0, got);
    do_xfer(8'($urandom), MODE_CBC, DIR_ENC, 0, 1'b0, got);
    do_xfer(8'($urandom), MODE_CBC, DIR_DEC, 0, 1'b0, got);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    reset_n       = 1'b0;
    key10_in      = '0;
    key_load      = 1'b0;
    iv_in         = '0;
    iv_load       = 1'b0;
    mode          = MODE_ECB;
    dir           = DIR_ENC;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    m_k1          = '0;
    m_k2          = '0;
    m_chain       = '0;
    m_count       = '0;

    test_reset();
    test_key_load(10'b0100000101, 1'b1);
    test_ecb();
    test_cbc();
    test_backpressure();
    test_wrap();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
